adc_capture_frontend: RTL and testbench
=======================================

# adc_capture_frontend

Parametrised ADC capture block between the digital core and the analog shell. It generates the ADC sample clock from the core clock with a programmable divider, and time-multiplexes up to NUM_CH converter channels round-robin. Each sample is captured and tagged with its channel, buffered in a FIFO, and presented to the digital side over a ready/valid stream. It supersedes the fixed 8-bit single-channel adc_clock/adc_data pair.

## Interface
- DATA_W, 8, ADC sample width
- NUM_CH, 2, number of multiplexed ADC channels (1..16)
- DEPTH, 8, FIFO entries (power of two, >=2)
- DIV_W, 8, width of clock-divider setting
- clock  in  1  core clock; sole clock domain
- reset  in  1  synchronous, active-high reset
- cfg_enable  in  1  capture enable
- cfg_div  in  DIV_W  half-period of adc_clock minus one, in core cycles
- cfg_ch_mask  in  NUM_CH  channel enable mask
- adc_clock  out  1  sample clock to analog shell
- adc_sel  out  max(1,$clog2(NUM_CH))  channel select to analog mux
- adc_data  in  DATA_W  converter output
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head
- out_data  out  DATA_W  head sample
- out_ch  out  max(1,$clog2(NUM_CH))  channel tag of head
- overflow  out  1  sticky: sample dropped because FIFO full
- overflow_clear  in  1  clears overflow

## Operation
- Run condition: cfg_enable=1 and cfg_ch_mask!=0. Otherwise the divider counter is held at 0, adc_clock is held low, and no samples are taken. FIFO contents remain and keep draining.
- Divider: div_cnt counts 0..div_lat. On the cycle div_cnt==div_lat, adc_clock toggles and div_cnt returns to 0. Period is 2*(cfg_div+1) cycles, so cfg_div=0 gives clock/2.
- div_lat latches cfg_div on entry to run and at every adc_clock falling edge. Changes mid-period do not affect the current period.
- Sample edge: the cycle on which adc_clock is registered high->low. On that cycle:
  - adc_data is captured together with the current adc_sel.
  - adc_sel advances to the next set bit of cfg_ch_mask above its current value, wrapping around.
- Run entry: adc_sel is set to the lowest set bit of cfg_ch_mask. If the mask changes so that adc_sel is no longer enabled, the next advance still picks the next set bit.
- FIFO push: a capture is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
- Dropped capture: overflow is set; FIFO contents are unchanged.
- Pop: on out_valid && out_ready.
- Simultaneous push and pop: count unchanged, ordering preserved.
- overflow_clear: clears overflow. If it coincides with a drop, set wins.
- Reset mid-operation: FIFO is flushed and all state returns to reset values on the next edge.
- Reset values: adc_clock=0, adc_sel=0, out_valid=0, out_data=0, out_ch=0, overflow=0, div_cnt=0, FIFO empty.

## Timing
- adc_clock and adc_sel are registered directly, with no combinational path from cfg_*.
- First rising edge of adc_clock: div_lat+1 cycles after cfg_enable is sampled high.
- Capture latency: a sample taken at cycle T appears with out_valid=1 at T+1 if the FIFO was empty.
- out_data and out_ch come from the FIFO head (first-word fall-through) and are stable while out_valid && !out_ready.
- Throughput: one pop per cycle; one push at most every 2 cycles.

## Structure
- Package adc_capture_pkg holds:
  - CH_W = max(1,$clog2(NUM_CH))
  - sample_t struct {ch [CH_W-1:0], data [DATA_W-1:0]}
  - function next_ch(mask, cur), the round-robin search
- Sub-module sync_fifo (parametrised WIDTH, DEPTH): registered pointers, count, first-word fall-through, push-when-full-with-pop rule.
- Top level: divider, channel sequencer, overflow flag.

## Test plan
- Single channel: DATA_W=8, NUM_CH=2, cfg_div=3, mask=01, ramp adc_data 0x10,0x11,… with out_ready=1.
  - adc_clock period is 8 cycles.
  - out_data sequence is 0x10,0x11,…, all with out_ch=0.
  - out_valid rises 1 cycle after each falling edge.
- Round-robin: mask=11, cfg_div=0.
  - out_ch alternates 0,1,0,1.
  - Switching mask to 10 mid-run yields only ch 1 after the next sample edge.
- Overflow: out_ready=0, DEPTH=8.
  - 8 samples accepted; the 9th sets overflow, and the FIFO still holds the first 8 in order.
  - overflow_clear then drops overflow; drain returns exactly those 8 samples.
- Full with simultaneous pop: FIFO full, out_ready=1 on a sample edge.
  - Push is accepted, count stays 8, overflow stays 0.
- cfg_div change and disable:
  - cfg_div changed 3->1 mid-high-phase: the current period stays 8 cycles, the next is 4.
  - cfg_enable=0: adc_clock goes low, and buffered data still drains.
- Reset mid-run with 5 entries buffered: next cycle out_valid=0, adc_clock=0, overflow=0, adc_sel=0.

Source files
------------

// File: rtl/adc_capture_frontend_pkg.sv
// ---------------------------------------------------------------------------
// adc_capture_pkg : shared types and the round-robin channel search
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adc_capture_pkg;

  localparam int MAX_CH     = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 2;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_width(DEF_NUM_CH);

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DEF_DATA_W-1:0] data;
  } sample_t;

  // Next set bit of mask strictly after cur, wrapping; cur=num_ch-1 yields the lowest set bit.
  function automatic logic [3:0] next_ch(input logic [MAX_CH-1:0] mask,
                                         input logic [3:0]        cur,
                                         input int                num_ch);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = (int'(cur) + i) % num_ch;
      if (!found && (i <= num_ch) && mask[idx[3:0]]) begin
        res   = idx[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_capture_frontend_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : first-word fall-through FIFO, accepts a push when full if a pop
//             happens in the same cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_accept,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign pop_valid   = (r_count != '0);
  assign w_pop       = pop_valid && pop_ready;
  assign push_accept = push && ((r_count < (AW+1)'(DEPTH)) || w_pop);
  assign pop_data    = pop_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)       r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push_accept, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_accept) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/adc_capture_frontend.sv
// ---------------------------------------------------------------------------
// adc_capture_frontend : ADC clock divider, round-robin channel sequencer,
//                        sample FIFO and sticky overflow flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_capture_frontend
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [NUM_CH-1:0]             cfg_ch_mask,
  output logic                          adc_clock,
  output logic [ch_width(NUM_CH)-1:0]   adc_sel,
  input  logic [DATA_W-1:0]             adc_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [ch_width(NUM_CH)-1:0]   out_ch,
  output logic                          overflow,
  input  logic                          overflow_clear
);

  localparam int SEL_W = ch_width(NUM_CH);
  localparam int W     = SEL_W + DATA_W;

  logic             r_running;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] r_div_lat;
  logic             w_run;
  logic             w_tick;
  logic             w_sample;
  logic             w_accept;
  logic [W-1:0]     w_head;
  logic [SEL_W-1:0] w_first_ch;
  logic [SEL_W-1:0] w_next_ch;

  assign w_run      = cfg_enable && (cfg_ch_mask != '0);
  assign w_tick     = r_running && w_run && (r_div_cnt == r_div_lat);
  assign w_sample   = w_tick && adc_clock;
  assign w_first_ch = SEL_W'(next_ch(MAX_CH'(cfg_ch_mask), 4'(NUM_CH - 1), NUM_CH));
  assign w_next_ch  = SEL_W'(next_ch(MAX_CH'(cfg_ch_mask), 4'(adc_sel), NUM_CH));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_running <= 1'b0;
      r_div_cnt <= '0;
      r_div_lat <= '0;
      adc_clock <= 1'b0;
      adc_sel   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (!w_run) begin
        r_running <= 1'b0;
        r_div_cnt <= '0;
        adc_clock <= 1'b0;
      end else if (!r_running) begin
        r_running <= 1'b1;
        r_div_cnt <= '0;
        r_div_lat <= cfg_div;
        adc_sel   <= w_first_ch;
      end else if (w_tick) begin
        r_div_cnt <= '0;
        adc_clock <= !adc_clock;
        // Falling edge: sample taken, next period's half-length latched.
        if (adc_clock) begin
          r_div_lat <= cfg_div;
          adc_sel   <= w_next_ch;
        end
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      if (w_sample && !w_accept) overflow <= 1'b1;
      else if (overflow_clear)   overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (w_sample),
    .push_data   ({adc_sel, adc_data}),
    .push_accept (w_accept),
    .pop_valid   (out_valid),
    .pop_ready   (out_ready),
    .pop_data    (w_head)
  );

  assign out_ch   = w_head[W-1 -: SEL_W];
  assign out_data = w_head[DATA_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_frontend.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_frontend : table-driven and hand-sequenced checks with a
//                           sample scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_capture_frontend;
  import adc_capture_pkg::*;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              cfg_enable;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] cfg_ch_mask;
  logic              adc_clock;
  logic [0:0]        adc_sel;
  logic [DATA_W-1:0] adc_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [0:0]        out_ch;
  logic              overflow;
  logic              overflow_clear;

  always #5 clock = ~clock;

  adc_capture_frontend #(
    .DATA_W (DATA_W), .NUM_CH (NUM_CH), .DEPTH (DEPTH), .DIV_W (DIV_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_enable     (cfg_enable),
    .cfg_div        (cfg_div),
    .cfg_ch_mask    (cfg_ch_mask),
    .adc_clock      (adc_clock),
    .adc_sel        (adc_sel),
    .adc_data       (adc_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_ch         (out_ch),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  typedef struct {
    logic [7:0] div;
    logic [1:0] mask;
    int         nsamp;
    int         period;
    logic [3:0] pat;     // expected channel of sample k is pat[k%4]
  } vec_t;

  vec_t       vecs[4];
  sample_t    sb[$];
  logic [0:0] exp_ch_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  int   nrise    = 0;
  int   nfall    = 0;
  int   npop     = 0;
  int   last_rise = 0, prev_rise = 0, last_fall = 0, prev_fall = 0;
  logic prev_clk = 1'b0;
  logic rose = 1'b0, fell = 1'b0;
  logic chk_vof = 1'b0;
  logic [7:0] ramp = 8'h0F;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cycle);
  endtask

  // One core cycle: score the handshake about to happen, then act as the converter.
  task automatic tick();
    sample_t    s;
    logic [0:0] ch;
    if (!reset && out_valid && out_ready) begin
      npop++;
      if (sb.size() == 0) timeout("unexpected_pop");
      else begin
        s = sb.pop_front();
        check("out_data", 32'(out_data), 32'(s.data));
        check("out_ch", 32'(out_ch), 32'(s.ch));
      end
    end
    @(negedge clock);
    cycle++;
    rose = 1'b0;
    fell = 1'b0;
    if (reset) prev_clk = 1'b0;
    else begin
      rose = adc_clock && !prev_clk;
      fell = !adc_clock && prev_clk;
      if (rose) begin
        ch = 1'b0;
        if (exp_ch_q.size() > 0) ch = exp_ch_q.pop_front();
        check("adc_sel", 32'(adc_sel), 32'(ch));
        ramp     = ramp + 8'd1;
        adc_data = ramp;
        s.ch     = ch;
        s.data   = ramp;
        sb.push_back(s);
        prev_rise = last_rise;
        last_rise = cycle;
        nrise++;
      end
      if (fell) begin
        prev_fall = last_fall;
        last_fall = cycle;
        nfall++;
        if (chk_vof) check("valid_after_fall", 32'(out_valid), 32'd1);
      end
      prev_clk = adc_clock;
    end
  endtask

  task automatic wait_falls(input int n);
    int target = nfall + n;
    int k = 0;
    while (nfall < target && k < 300) begin tick(); k++; end
    if (nfall < target) timeout("wait_falls");
  endtask

  task automatic drain(input int expn, input string name);
    int p0 = npop;
    int k = 0;
    out_ready = 1'b1;
    while (out_valid && k < 50) begin tick(); k++; end
    if (expn >= 0) check(name, 32'(npop - p0), 32'(expn));
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int c0, r0, f0, k;
    exp_ch_q.delete();
    for (int i = 0; i < v.nsamp; i++) exp_ch_q.push_back(v.pat[i % 4]);
    cfg_div     = v.div;
    cfg_ch_mask = v.mask;
    out_ready   = 1'b1;
    chk_vof     = 1'b1;
    cfg_enable  = 1'b1;
    c0 = cycle; r0 = nrise; f0 = nfall; k = 0;
    while ((nfall - f0) < v.nsamp && k < 400) begin
      tick();
      k++;
      if (rose) begin
        if (nrise - r0 == 1) check("first_rise_latency", 32'(cycle - c0), 32'(int'(v.div) + 2));
        else                 check("period", 32'(last_rise - prev_rise), 32'(v.period));
      end
    end
    if ((nfall - f0) < v.nsamp) timeout("run_vec");
    cfg_enable = 1'b0;
    chk_vof    = 1'b0;
    tick();
    check("clock_low_disabled", 32'(adc_clock), 32'd0);
    drain(-1, "drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{div: 8'd3, mask: 2'b01, nsamp: 4, period: 8, pat: 4'b0000};
    vecs[1] = '{div: 8'd0, mask: 2'b11, nsamp: 6, period: 2, pat: 4'b1010};
    vecs[2] = '{div: 8'd1, mask: 2'b10, nsamp: 4, period: 4, pat: 4'b1111};
    vecs[3] = '{div: 8'd2, mask: 2'b11, nsamp: 4, period: 6, pat: 4'b1010};

    reset = 1'b1; cfg_enable = 1'b0; cfg_div = '0; cfg_ch_mask = '0;
    adc_data = '0; out_ready = 1'b0; overflow_clear = 1'b0;
    repeat (3) tick();
    check("rst_adc_clock", 32'(adc_clock), 32'd0);
    check("rst_adc_sel", 32'(adc_sel), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Mask narrowed to ch1 right after a ch1 sample: one more ch0, then ch1 only.
    exp_ch_q.delete();
    foreach (vecs[0].pat[i]) begin end
    exp_ch_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    cfg_div = 8'd0; cfg_ch_mask = 2'b11; out_ready = 1'b1; chk_vof = 1'b1;
    cfg_enable = 1'b1;
    wait_falls(4);
    cfg_ch_mask = 2'b10;
    wait_falls(4);
    cfg_enable = 1'b0; chk_vof = 1'b0;
    drain(-1, "drain_mask");

    // Overflow: ninth sample dropped, first eight retained in order.
    exp_ch_q = '{9{1'b0}};
    cfg_div = 8'd0; cfg_ch_mask = 2'b01; out_ready = 1'b0;
    cfg_enable = 1'b1;
    wait_falls(8);
    check("no_overflow_at_8", 32'(overflow), 32'd0);
    wait_falls(1);
    cfg_enable = 1'b0;
    check("overflow_set", 32'(overflow), 32'd1);
    void'(sb.pop_back());
    tick();
    check("overflow_sticky", 32'(overflow), 32'd1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'd0);
    drain(8, "drain_after_overflow");

    // Full FIFO with a pop on the sample edge: push accepted, no overflow.
    exp_ch_q = '{9{1'b0}};
    out_ready = 1'b0;
    cfg_enable = 1'b1;
    wait_falls(8);
    k = 0;
    do begin tick(); k++; end while (!rose && k < 20);
    if (!rose) timeout("full_pop_rise");
    out_ready = 1'b1;
    tick();
    check("full_pop_edge", 32'(fell), 32'd1);
    check("full_pop_no_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b0;
    cfg_enable = 1'b0;
    repeat (2) tick();
    check("full_pop_overflow_later", 32'(overflow), 32'd0);
    drain(8, "drain_full_pop");

    // Divider change mid-high-phase, then disable while high.
    exp_ch_q = '{5{1'b0}};
    cfg_div = 8'd3; out_ready = 1'b0;
    cfg_enable = 1'b1;
    wait_falls(1);
    k = 0;
    do begin tick(); k++; end while (!rose && k < 20);
    tick(); tick();
    cfg_div = 8'd1;
    wait_falls(1);
    check("period_before_change", 32'(last_fall - prev_fall), 32'd8);
    wait_falls(1);
    check("period_after_change", 32'(last_fall - prev_fall), 32'd4);
    k = 0;
    do begin tick(); k++; end while (!rose && k < 20);
    cfg_enable = 1'b0;
    void'(sb.pop_back());
    tick();
    check("clock_low_on_disable", 32'(adc_clock), 32'd0);
    check("valid_while_disabled", 32'(out_valid), 32'd1);
    drain(3, "drain_after_disable");

    // Reset with five entries buffered.
    exp_ch_q = '{5{1'b1}};
    cfg_div = 8'd0; cfg_ch_mask = 2'b10; out_ready = 1'b0;
    cfg_enable = 1'b1;
    wait_falls(5);
    check("pre_reset_sel", 32'(adc_sel), 32'd1);
    reset = 1'b1; cfg_enable = 1'b0;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_adc_clock", 32'(adc_clock), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_adc_sel", 32'(adc_sel), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    sb.delete();
    exp_ch_q.delete();
    tick();
    check("post_rst_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
